rsc_turbo_encoder: RTL and testbench

- Streaming recursive systematic convolutional (RSC) constituent encoder; the transmit-side counterpart of max_product_symbol.
- Takes one data bit per handshake and emits one NOUT-bit code symbol per bit. Symbol indexing matches the decoder's branch_metric[OUTPUT_SYMBOLS] addressing.
- After FRAME_LEN data bits, appends log2(STATES) tail symbols that drive the encoder back to state 0, so the decoder's alpha/beta recursions start and end in state 0.
- Uses the same trellis parameters as trellis_if, so both ends share one code definition.

---
 rtl/rsc_turbo_encoder.sv | 140 ++++++++++++++
 tb/tb_rsc_turbo_encoder.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rsc_turbo_encoder.sv
`default_nettype none
// ============================================================================
// Module      : rsc_turbo_encoder
// Description : Streaming recursive systematic convolutional constituent
//               encoder. One data bit in, one NOUT-bit symbol out per step,
//               followed by M = log2(STATES) tail symbols that return the
//               trellis to state 0 at the end of every frame.
// Revision    : 1.0 - initial release
// ============================================================================
module rsc_turbo_encoder #(
    parameter int STATES      = 4,
    parameter int NOUT        = 2,
    parameter int RECURSIVE   = 7,
    parameter int POLY [NOUT] = '{5, 7},
    parameter int FRAME_LEN   = 16,
    localparam int M          = $clog2(STATES)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            in_bit,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [NOUT-1:0] out_symbol,
    output logic            out_tail,
    output logic            out_last,
    output logic [M-1:0]    out_state
);

    localparam int BW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam int TW = (M > 1) ? $clog2(M) : 1;

    localparam logic [BW-1:0] LAST_BIT  = BW'(FRAME_LEN - 1);
    localparam logic [TW-1:0] LAST_TAIL = TW'(M - 1);
    localparam logic [M:0]    REC_BITS  = RECURSIVE[M:0];

    localparam logic [0:0] ST_DATA = 1'b0;
    localparam logic [0:0] ST_TAIL = 1'b1;

    logic [0:0]      fsm;
    logic [M-1:0]    s;
    logic [BW-1:0]   bit_cnt;
    logic [TW-1:0]   tail_cnt;

    logic            slot_free;
    logic            data_step;
    logic            tail_step;
    logic            step;
    logic            fb;
    logic            u;
    logic            w;
    logic            last_bit;
    logic            last_tail;
    logic [M-1:0]    next_s;
    logic [NOUT-1:0] sym;

    assign slot_free = !out_valid || out_ready;
    assign in_ready  = (fsm == ST_DATA) && slot_free;
    assign data_step = in_valid && in_ready;
    assign tail_step = (fsm == ST_TAIL) && slot_free;
    assign step      = data_step || tail_step;
    assign last_bit  = (bit_cnt == LAST_BIT);
    assign last_tail = (tail_cnt == LAST_TAIL);

    // Feedback node; in the tail the input cancels the feedback so w = 0
    assign fb = ^(REC_BITS[M-1:0] & s);
    assign u  = (fsm == ST_TAIL) ? fb : in_bit;
    assign w  = u ^ fb;

    // Shift the new feedback value into the most recent delay element
    generate
        if (M == 1) begin : g_m1
            assign next_s = w;
        end else begin : g_mn
            assign next_s = {w, s[M-1:1]};
        end
    endgenerate

    // Output bit j is the parity of POLY[j] over {w, s}
    always_comb begin
        logic [31:0] p;
        sym = '0;
        p   = '0;
        for (int j = 0; j < NOUT; j++) begin
            p      = 32'(POLY[j]);
            sym[j] = ^(p[M:0] & {w, s});
        end
    end

    // Frame sequencing: data bit counter, then tail counter, then back to data
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm      <= ST_DATA;
            bit_cnt  <= '0;
            tail_cnt <= '0;
            s        <= '0;
        end else begin
            if (data_step) begin
                s <= next_s;
                if (last_bit) begin
                    bit_cnt <= '0;
                    fsm     <= ST_TAIL;
                end else begin
                    bit_cnt <= bit_cnt + 1'b1;
                end
            end else if (tail_step) begin
                if (last_tail) begin
                    tail_cnt <= '0;
                    s        <= '0;
                    fsm      <= ST_DATA;
                end else begin
                    tail_cnt <= tail_cnt + 1'b1;
                    s        <= next_s;
                end
            end
        end
    end

    // Output symbol register; reloads on any step, empties when consumed unreplaced
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            out_symbol <= '0;
            out_tail   <= 1'b0;
            out_last   <= 1'b0;
            out_state  <= '0;
        end else if (step) begin
            out_valid  <= 1'b1;
            out_symbol <= sym;
            out_tail   <= tail_step;
            out_last   <= tail_step && last_tail;
            out_state  <= next_s;
        end else if (out_ready) begin
            out_valid  <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rsc_turbo_encoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_rsc_turbo_encoder
// Description : Self-checking bench for rsc_turbo_encoder (FRAME_LEN = 4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rsc_turbo_encoder;

    typedef struct {
        logic       bit_in;
        logic [1:0] sym;
        logic [1:0] st;
        logic       tail;
        logic       last;
    } rec_t;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic       in_bit;
    logic       out_valid;
    logic       out_ready;
    logic [1:0] out_symbol;
    logic       out_tail;
    logic       out_last;
    logic [1:0] out_state;

    int tests;
    int fails;
    int cyc;

    rec_t ref_tbl  [6];
    rec_t zero_tbl [6];
    rec_t sb [$];
    int   cons_cyc [$];

    rec_t       e;
    logic       held_v;
    logic [1:0] held_sym;
    logic [1:0] held_st;
    logic       held_tail;
    logic       held_last;

    rsc_turbo_encoder #(
        .STATES    (4),
        .NOUT      (2),
        .RECURSIVE (7),
        .POLY      ('{5, 7}),
        .FRAME_LEN (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_bit     (in_bit),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_symbol (out_symbol),
        .out_tail   (out_tail),
        .out_last   (out_last),
        .out_state  (out_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard consumer plus stall/tail handshake checks, sampled mid-cycle
    always @(negedge clk) begin
        cyc++;
        if (rst_n && held_v) begin
            chk("hold_symbol", out_symbol, held_sym);
            chk("hold_state", out_state, held_st);
            chk("hold_tail", out_tail, held_tail);
            chk("hold_last", out_last, held_last);
            chk("hold_valid", out_valid, 1);
        end
        if (rst_n && out_valid && !out_ready)
            chk("in_ready_stall", in_ready, 0);
        if (rst_n && out_valid && out_tail && !out_last)
            chk("in_ready_tail", in_ready, 0);
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_symbol", 1, 0);
            end else begin
                e = sb.pop_front();
                chk("symbol", out_symbol, e.sym);
                chk("state", out_state, e.st);
                chk("tail", out_tail, e.tail);
                chk("last", out_last, e.last);
                if (!e.tail)
                    chk("systematic_bit", out_symbol[1], e.bit_in);
                cons_cyc.push_back(cyc);
            end
        end
        held_v    = rst_n && out_valid && !out_ready;
        held_sym  = out_symbol;
        held_st   = out_state;
        held_tail = out_tail;
        held_last = out_last;
    end

    // Drive a bit stream; mode 0 = ready high, mode 1 = ready pattern 1,0,0,1
    task automatic run_frame(input logic [15:0] bits, input int nbits, input int mode);
        int  k;
        int  n;
        logic [3:0] pat;
        pat = 4'b1001;
        k = 0;
        n = 0;
        while ((k < nbits || sb.size() != 0) && n < 300) begin
            @(posedge clk);
            #1;
            out_ready = (mode == 0) ? 1'b1 : pat[n % 4];
            in_valid  = (k < nbits);
            in_bit    = (k < nbits) ? bits[k] : 1'($urandom);
            #1;
            if (in_valid && in_ready) k++;
            n++;
        end
        if (n >= 300) chk("frame_timeout", n, 0);
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
    endtask

    task automatic push_tbl(input int which);
        for (int i = 0; i < 6; i++)
            sb.push_back(which == 0 ? ref_tbl[i] : zero_tbl[i]);
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_valid"}, out_valid, 0);
        chk({tag, "_symbol"}, out_symbol, 0);
        chk({tag, "_tail"}, out_tail, 0);
        chk({tag, "_last"}, out_last, 0);
        chk({tag, "_state"}, out_state, 0);
    endtask

    initial begin
        int acc;
        int n;
        tests = 0;
        fails = 0;
        cyc = 0;
        held_v = 1'b0;

        // Reference frame 1,0,1,1: symbols 3,1,2,2,1,3; states 2,3,3,3,1,0
        ref_tbl[0] = '{1'b1, 2'd3, 2'd2, 1'b0, 1'b0};
        ref_tbl[1] = '{1'b0, 2'd1, 2'd3, 1'b0, 1'b0};
        ref_tbl[2] = '{1'b1, 2'd2, 2'd3, 1'b0, 1'b0};
        ref_tbl[3] = '{1'b1, 2'd2, 2'd3, 1'b0, 1'b0};
        ref_tbl[4] = '{1'b0, 2'd1, 2'd1, 1'b1, 1'b0};
        ref_tbl[5] = '{1'b0, 2'd3, 2'd0, 1'b1, 1'b1};
        for (int i = 0; i < 6; i++)
            zero_tbl[i] = '{1'b0, 2'd0, 2'd0, (i >= 4), (i == 5)};

        rst_n = 1'b0;
        in_valid = 1'b0;
        in_bit = 1'b0;
        out_ready = 1'b1;
        #12;
        chk_outputs_zero("reset");
        #10;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("in_ready_after_reset", in_ready, 1);

        // Reference frame, ready held high
        push_tbl(0);
        run_frame(16'b1101, 4, 0);

        // All-zero frame
        push_tbl(1);
        run_frame(16'b0000, 4, 0);

        // Reference frame under backpressure
        push_tbl(0);
        run_frame(16'b1101, 4, 1);

        // Back-to-back frames, 12 contiguous symbols
        cons_cyc.delete();
        push_tbl(0);
        push_tbl(0);
        run_frame(16'b1101_1101, 8, 0);
        if (cons_cyc.size() == 12)
            chk("back_to_back_gap", cons_cyc[11] - cons_cyc[0], 11);
        else
            chk("back_to_back_count", cons_cyc.size(), 12);

        // Reset mid-frame after the 2nd data bit
        sb.push_back(ref_tbl[0]);
        sb.push_back(ref_tbl[1]);
        acc = 0;
        n = 0;
        while (acc < 2 && n < 50) begin
            @(posedge clk);
            #1;
            out_ready = 1'b1;
            in_valid  = 1'b1;
            in_bit    = (acc == 0) ? 1'b1 : 1'b0;
            #1;
            if (in_ready) acc++;
            n++;
        end
        if (n >= 50) chk("midreset_timeout", n, 0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        #2;
        chk("midreset_queue_drained", sb.size(), 0);
        rst_n = 1'b0;
        #1;
        chk_outputs_zero("midreset");
        sb.delete();
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("in_ready_after_midreset", in_ready, 1);
        push_tbl(0);
        run_frame(16'b1101, 4, 0);

        repeat (3) @(posedge clk);
        #1;
        chk("idle_valid_low", out_valid, 0);
        chk("scoreboard_empty", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
